aes_inv_key_schedule: RTL and testbench

//  Decryption-side round-key generator. Loads the 128-bit cipher key and runs the

---
 rtl/aes_pkg.sv | 31 +++
 rtl/aes_sub_bytes.sv | 49 ++++
 rtl/aes_inv_key_schedule.sv | 132 +++++++++++++
 tb/tb_aes_inv_key_schedule.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants: key width, round count, FSM encodings and round constants.
package aes_pkg;

    localparam int AES_KEY_W = 128;
    localparam int AES_NR    = 10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FWD   = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;
    localparam logic [1:0] ST_INV   = 2'd3;

    // Round constant for table index idx (round r uses idx = r-1).
    function automatic logic [7:0] aes_rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_sub_bytes.sv
// Single-byte AES S-box, forward or inverse, built from the GF(2^8) inverse
// plus the affine map so no 256-entry table is needed.
module aes_sub_bytes (
    input  logic [7:0] byte_in,
    input  logic       inv_en,
    output logic [7:0] byte_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 == a^-1 for a != 0, and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
                 ^ {a[3:0], a[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] a);
        return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    endfunction

    // Pure combinational substitution.
    always_comb begin
        if (inv_en) byte_o = gf_inv(inv_affine(byte_in));
        else        byte_o = affine(gf_inv(byte_in));
    end

endmodule

// File: rtl/aes_inv_key_schedule.sv
// Decryption-side AES-128 round-key generator. Expands forward to round 10,
// then walks back one round per step_req, one S-box lookup per cycle.
module aes_inv_key_schedule
    import aes_pkg::*;
#(
    parameter int KEY_WIDTH = AES_KEY_W,
    parameter int NR        = AES_NR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_load,
    input  logic [KEY_WIDTH-1:0] key_in,
    input  logic                 step_req,
    output logic                 busy,
    output logic                 rk_valid,
    output logic [3:0]           rk_round,
    output logic [KEY_WIDTH-1:0] rk_o
);

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  round_q, round_d;
    logic [31:0] w0_q, w1_q, w2_q, w3_q;
    logic [31:0] w0_d, w1_d, w2_d, w3_d;
    logic [7:0]  sub_q [4];
    logic [7:0]  sub_d [4];

    logic [31:0] src_w, rot_w, g_w;
    logic [7:0]  sb_in, sb_out;

    // Byte feeding the S-box: RotWord(w3) going forward, RotWord(w3^w2) going back
    // (w3^w2 recovers the previous round's w3). Bytes are issued MSB-first.
    always_comb begin
        src_w = (state_q == ST_INV) ? (w3_q ^ w2_q) : w3_q;
        rot_w = {src_w[23:0], src_w[31:24]};
        case (cnt_q[1:0])
            2'd0:    sb_in = rot_w[31:24];
            2'd1:    sb_in = rot_w[23:16];
            2'd2:    sb_in = rot_w[15:8];
            default: sb_in = rot_w[7:0];
        endcase
    end

    aes_sub_bytes u_sbox (
        .byte_in (sb_in),
        .inv_en  (1'b0),
        .byte_o  (sb_out)
    );

    assign g_w = {sub_q[0], sub_q[1], sub_q[2], sub_q[3]} ^ {aes_rcon(round_q - 4'd1), 24'h0};

    // Next-state: load, byte-serial substitution, then word write-back on cnt 4.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        round_d = round_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        w3_d    = w3_q;
        sub_d   = sub_q;
        case (state_q)
            ST_IDLE, ST_READY: begin
                if (key_load) begin
                    w0_d    = key_in[127:96];
                    w1_d    = key_in[95:64];
                    w2_d    = key_in[63:32];
                    w3_d    = key_in[31:0];
                    cnt_d   = 3'd0;
                    round_d = 4'd1;
                    state_d = ST_FWD;
                end else if (state_q == ST_READY && step_req && round_q != 4'd0) begin
                    cnt_d   = 3'd0;
                    state_d = ST_INV;
                end
            end
            ST_FWD, ST_INV: begin
                if (cnt_q != 3'd4) begin
                    sub_d[cnt_q[1:0]] = sb_out;
                    cnt_d             = cnt_q + 3'd1;
                end else begin
                    cnt_d = 3'd0;
                    if (state_q == ST_FWD) begin
                        w0_d = w0_q ^ g_w;
                        w1_d = w1_q ^ w0_d;
                        w2_d = w2_q ^ w1_d;
                        w3_d = w3_q ^ w2_d;
                        if (round_q == NR[3:0]) state_d = ST_READY;
                        else                    round_d = round_q + 4'd1;
                    end else begin
                        w3_d    = w3_q ^ w2_q;
                        w2_d    = w2_q ^ w1_q;
                        w1_d    = w1_q ^ w0_q;
                        w0_d    = w0_q ^ g_w;
                        round_d = round_q - 4'd1;
                        state_d = ST_READY;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            round_q <= '0;
            w0_q    <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            w3_q    <= '0;
            for (int i = 0; i < 4; i++) sub_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            w3_q    <= w3_d;
            sub_q   <= sub_d;
        end
    end

    assign busy     = (state_q == ST_FWD) || (state_q == ST_INV);
    assign rk_valid = (state_q == ST_READY);
    assign rk_round = round_q;
    assign rk_o     = {w0_q, w1_q, w2_q, w3_q};

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for the inverse key schedule: an independent forward-expansion
// model produces every round key, expectations are queued at stimulus time and
// popped when rk_valid rises.
module tb_aes_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_load = 1'b0;
    logic         step_req = 1'b0;
    logic [127:0] key_in = '0;
    logic         busy, rk_valid;
    logic [3:0]   rk_round;
    logic [127:0] rk_o;

    always #5 clk = ~clk;

    aes_inv_key_schedule dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_load (key_load),
        .key_in   (key_in),
        .step_req (step_req),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_round (rk_round),
        .rk_o     (rk_o)
    );

    localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K1R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K1R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] K1R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K0R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };
    logic [7:0] RCON_T [10] = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

    typedef struct packed {
        logic [3:0]   rnd;
        logic [127:0] key;
    } exp_t;

    exp_t         sb_q [$];
    logic [127:0] mdl [11];
    int           n_assert = 0;
    int           n_fail   = 0;
    int           cur      = 0;

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    endfunction

    // Forward FIPS-197 expansion into mdl[0..10].
    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = subw({t[23:0], t[31:24]}) ^ {RCON_T[i/4-1], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) mdl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accepted key load (optionally with a simultaneous step_req that must lose).
    task automatic load_key(input logic [127:0] k, input logic also_step);
        model_expand(k);
        @(negedge clk);
        key_in   = k;
        key_load = 1'b1;
        step_req = also_step;
        sb_q.push_back('{rnd: 4'd10, key: mdl[10]});
        cur = 10;
        @(negedge clk);
        key_load = 1'b0;
        step_req = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        step_req = 1'b1;
        if (cur > 0) begin
            sb_q.push_back('{rnd: 4'(cur - 1), key: mdl[cur-1]});
            cur--;
        end
        @(negedge clk);
        step_req = 1'b0;
    endtask

    // Wait (bounded) for rk_valid, check latency, then pop and compare.
    task automatic wait_result(input string tag, input int exp_cyc, input int already);
        int   cyc;
        exp_t e;
        cyc = already;
        while (!rk_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, 128'(cyc), 128'(exp_cyc));
        chk({tag, "_sb_nonempty"}, 128'(sb_q.size() != 0), 128'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_round"}, 128'(rk_round), 128'(e.rnd));
            chk({tag, "_key"}, rk_o, e.key);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_valid", 128'(rk_valid), 128'd0);
        chk("rst_round", 128'(rk_round), 128'd0);
        chk("rst_rk", rk_o, 128'd0);
        rst_n = 1'b1;

        // step_req in IDLE is ignored
        @(negedge clk) step_req = 1'b1;
        @(negedge clk) step_req = 1'b0;
        chk("idle_step_busy", 128'(busy), 128'd0);
        chk("idle_step_valid", 128'(rk_valid), 128'd0);

        // T1: FIPS-197 key, forward to round 10
        load_key(K1, 1'b0);
        chk("t1_busy", 128'(busy), 128'd1);
        wait_result("t1", 50, 0);
        chk("t1_fips_r10", rk_o, K1R10);

        // T2: one step back
        step();
        chk("t2_busy", 128'(busy), 128'd1);
        chk("t2_valid", 128'(rk_valid), 128'd0);
        wait_result("t2", 5, 0);
        chk("t2_fips_r9", rk_o, K1R9);

        // T3: remaining steps down to round 0
        for (int i = 0; i < 9; i++) begin
            step();
            wait_result("t3", 5, 0);
            if (cur == 1) chk("t3_fips_r1", rk_o, K1R1);
        end
        chk("t3_r0_key", rk_o, K1);
        chk("t3_r0_round", 128'(rk_round), 128'd0);

        // Step at round 0 is ignored
        step();
        chk("t3_r0_step_busy", 128'(busy), 128'd0);
        repeat (6) @(negedge clk);
        chk("t3_r0_hold_valid", 128'(rk_valid), 128'd1);
        chk("t3_r0_hold_key", rk_o, K1);
        chk("t3_r0_hold_round", 128'(rk_round), 128'd0);

        // T4: pulses mid-FWD ignored (cycle count and key unchanged)
        load_key(K2, 1'b0);
        repeat (10) @(negedge clk);
        key_in   = K1;
        key_load = 1'b1;
        step_req = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        step_req = 1'b0;
        wait_result("t4_fwd", 50, 11);

        // Pulses mid-INV ignored
        step();
        @(negedge clk);
        key_in   = K1;
        key_load = 1'b1;
        step_req = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        step_req = 1'b0;
        wait_result("t4_inv", 5, 2);

        // key_load and step_req together in READY: load wins
        load_key(K1, 1'b1);
        chk("t4_both_busy", 128'(busy), 128'd1);
        chk("t4_both_valid", 128'(rk_valid), 128'd0);
        wait_result("t4_both", 50, 0);

        // T5: asynchronous reset 23 cycles into FWD
        load_key(K2, 1'b0);
        repeat (23) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 128'(busy), 128'd0);
        chk("t5_valid", 128'(rk_valid), 128'd0);
        chk("t5_rk", rk_o, 128'd0);
        chk("t5_round", 128'(rk_round), 128'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        load_key(K2, 1'b0);
        wait_result("t5_reload", 50, 0);

        // T6: all-zero key, full walk back
        load_key(128'd0, 1'b0);
        wait_result("t6", 50, 0);
        chk("t6_r10", rk_o, K0R10);
        for (int i = 0; i < 10; i++) begin
            step();
            wait_result("t6_step", 5, 0);
        end
        chk("t6_r0_key", rk_o, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
